// File: rtl/memory_access_if.sv
// ---------------------------------------------------------------------------
// memory_access_if
// Data-memory bus between the memory stage (master) and the data memory
// (slave). A request is held stable from assertion until the edge on which
// mem_ack is sampled high.
//   mem_req    master -> slave  bus request
//   mem_we     master -> slave  1 = write
//   mem_addr   master -> slave  word-aligned byte address
//   mem_wdata  master -> slave  lane-replicated store data
//   mem_wstrb  master -> slave  byte enables (0 for reads)
//   mem_rdata  slave -> master  read data, valid with mem_ack
//   mem_ack    slave -> master  completes the current request
// ---------------------------------------------------------------------------
interface memory_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_rdata,
      output mem_ack
   );
endinterface

// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access
// Memory stage sitting directly after execute. Non-memory instructions pass
// their result to writeback with one cycle of latency. Loads and stores are
// checked for a legal width code and natural alignment, then issued on the
// data-memory bus; execute is stalled (in_ready low) until the bus access
// completes or times out. All outputs are registered.
//   clk, reset   clock and asynchronous active-high reset
//   in_valid/in_ready, is_load, is_store, func3, result, store_data, dest_i
//                instruction from execute
//   mem          data-memory bus (master side)
//   wb_valid, wb_data, wb_dest
//                writeback result; wb_valid is a one-cycle pulse
//   fault        pulses with wb_valid for misaligned access / bad func3
//   bus_error    pulses with wb_valid when the bus does not answer in time
// ---------------------------------------------------------------------------
module memory_access #(
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   is_load,
   input  logic                   is_store,
   input  logic [2:0]             func3,
   input  logic [31:0]            result,
   input  logic [31:0]            store_data,
   input  logic [4:0]             dest_i,
   memory_access_if.master        mem,
   output logic                   wb_valid,
   output logic [31:0]            wb_data,
   output logic [4:0]             wb_dest,
   output logic                   fault,
   output logic                   bus_error
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   // Last counter value before the timeout fires: the request is then high
   // for exactly TIMEOUT cycles.
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   // ------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------

   // Width code / alignment legality for a load or store.
   function automatic logic access_legal(input logic        store,
                                         input logic [2:0]  f3,
                                         input logic [1:0]  off);
      logic ok;
      case (f3)
         3'b000:  ok = 1'b1;
         3'b001:  ok = (off[0] == 1'b0);
         3'b010:  ok = (off == 2'b00);
         3'b100:  ok = ~store;
         3'b101:  ok = ~store & (off[0] == 1'b0);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte enables for a store of the given width at the given offset.
   function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                             input logic [1:0] off);
      logic [3:0] strb;
      case (f3)
         3'b000:  strb = 4'b0001 << off;
         3'b001:  strb = off[1] ? 4'b1100 : 4'b0011;
         3'b010:  strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Store data replicated across every lane it may land in.
   function automatic logic [31:0] store_lanes(input logic [2:0]  f3,
                                               input logic [31:0] sd);
      logic [31:0] wd;
      case (f3)
         3'b000:  wd = {4{sd[7:0]}};
         3'b001:  wd = {2{sd[15:0]}};
         default: wd = sd;
      endcase
      return wd;
   endfunction

   // Select the addressed byte/half of a read word and extend it.
   function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] v;
      b = rd[{off, 3'b000} +: 8];
      h = off[1] ? rd[31:16] : rd[15:0];
      case (f3)
         3'b000:  v = {{24{b[7]}}, b};
         3'b001:  v = {{16{h[15]}}, h};
         3'b100:  v = {24'h000000, b};
         3'b101:  v = {16'h0000, h};
         default: v = rd;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [0:0]  state_r;
   logic        in_ready_r;
   logic [15:0] cnt_r;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic [4:0]  dest_r;
   logic        store_r;

   logic        mem_req_r;
   logic        mem_we_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;
   logic [3:0]  mem_wstrb_r;

   logic        wb_valid_r;
   logic [31:0] wb_data_r;
   logic [4:0]  wb_dest_r;
   logic        fault_r;
   logic        bus_error_r;

   logic        mem_op_s;
   logic        legal_s;
   logic [3:0]  strb_s;
   logic [31:0] wdata_s;
   logic        accept_s;

   // Decode of the instruction currently offered by execute.
   always_comb begin
      mem_op_s = is_load | is_store;
      legal_s  = 1'b0;
      strb_s   = 4'b0000;
      wdata_s  = 32'h0000_0000;
      accept_s = in_valid & in_ready_r;
      if (mem_op_s) begin
         legal_s = access_legal(is_store, func3, result[1:0]);
      end else begin
         legal_s = 1'b0;
      end
      if (is_store) begin
         strb_s  = store_strb(func3, result[1:0]);
         wdata_s = store_lanes(func3, store_data);
      end else begin
         strb_s  = 4'b0000;
         wdata_s = 32'h0000_0000;
      end
   end

   // Stage FSM, bus request registers and writeback registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         cnt_r       <= 16'h0000;
         f3_r        <= 3'b000;
         off_r       <= 2'b00;
         dest_r      <= 5'd0;
         store_r     <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mem_wstrb_r <= 4'b0000;
         wb_valid_r  <= 1'b0;
         wb_data_r   <= 32'h0000_0000;
         wb_dest_r   <= 5'd0;
         fault_r     <= 1'b0;
         bus_error_r <= 1'b0;
      end else begin
         // Pulses default low; data/dest hold until the next pulse.
         wb_valid_r  <= 1'b0;
         fault_r     <= 1'b0;
         bus_error_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // Any mem_ack seen here belongs to an abandoned request.
               if (accept_s) begin
                  if (!mem_op_s) begin
                     wb_valid_r <= 1'b1;
                     wb_data_r  <= result;
                     wb_dest_r  <= dest_i;
                  end else if (!legal_s) begin
                     wb_valid_r <= 1'b1;
                     fault_r    <= 1'b1;
                     wb_data_r  <= result;
                     wb_dest_r  <= 5'd0;
                  end else begin
                     state_r     <= ST_WAIT;
                     in_ready_r  <= 1'b0;
                     cnt_r       <= 16'h0000;
                     f3_r        <= func3;
                     off_r       <= result[1:0];
                     store_r     <= is_store;
                     dest_r      <= is_store ? 5'd0 : dest_i;
                     mem_req_r   <= 1'b1;
                     mem_we_r    <= is_store;
                     mem_addr_r  <= {result[31:2], 2'b00};
                     mem_wdata_r <= wdata_s;
                     mem_wstrb_r <= strb_s;
                  end
               end
            end
            ST_WAIT: begin
               // Ack has priority over a timeout on the same edge.
               if (mem.mem_ack) begin
                  state_r     <= ST_IDLE;
                  in_ready_r  <= 1'b1;
                  cnt_r       <= 16'h0000;
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  mem_wstrb_r <= 4'b0000;
                  wb_valid_r  <= 1'b1;
                  wb_dest_r   <= dest_r;
                  wb_data_r   <= store_r ? 32'h0000_0000
                                         : load_extract(f3_r, off_r, mem.mem_rdata);
               end else if (cnt_r == CNT_LAST) begin
                  state_r     <= ST_IDLE;
                  in_ready_r  <= 1'b1;
                  cnt_r       <= 16'h0000;
                  mem_req_r   <= 1'b0;
                  mem_we_r    <= 1'b0;
                  mem_wstrb_r <= 4'b0000;
                  wb_valid_r  <= 1'b1;
                  bus_error_r <= 1'b1;
                  wb_dest_r   <= 5'd0;
                  wb_data_r   <= 32'h0000_0000;
               end else begin
                  cnt_r <= cnt_r + 16'h0001;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               in_ready_r <= 1'b1;
               mem_req_r  <= 1'b0;
               cnt_r      <= 16'h0000;
            end
         endcase
      end
   end

   assign in_ready      = in_ready_r;
   assign mem.mem_req   = mem_req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_wdata = mem_wdata_r;
   assign mem.mem_wstrb = mem_wstrb_r;
   assign wb_valid      = wb_valid_r;
   assign wb_data       = wb_data_r;
   assign wb_dest       = wb_dest_r;
   assign fault         = fault_r;
   assign bus_error     = bus_error_r;

endmodule

// File: tb/tb_memory_access.sv
// ---------------------------------------------------------------------------
// tb_memory_access
// Scoreboard bench: each issued instruction pushes its expected writeback
// record; a monitor pops and compares on every wb_valid pulse. Bus-side
// properties (address, strobes, data, stability, request duration) are
// checked by the issuing task while it plays the memory.
// ---------------------------------------------------------------------------
module tb_memory_access;

   localparam int TMO = 4;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  dest;
      logic        flt;
      logic        berr;
      bit          chk_data;
   } wb_exp_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  func3;
   logic [31:0] result;
   logic [31:0] store_data;
   logic [4:0]  dest_i;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic        fault;
   logic        bus_error;

   int n_checks;
   int n_fail;
   wb_exp_t sb[$];

   memory_access_if bus_if ();

   memory_access #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .is_load    (is_load),
      .is_store   (is_store),
      .func3      (func3),
      .result     (result),
      .store_data (store_data),
      .dest_i     (dest_i),
      .mem        (bus_if),
      .wb_valid   (wb_valid),
      .wb_data    (wb_data),
      .wb_dest    (wb_dest),
      .fault      (fault),
      .bus_error  (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Writeback monitor: every pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!reset && wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check_eq("unexpected_wb", 32'd1, 32'd0);
         end else begin
            wb_exp_t e;
            e = sb.pop_front();
            if (e.chk_data) check_eq("wb_data", wb_data, e.data);
            check_eq("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
            check_eq("fault", {31'd0, fault}, {31'd0, e.flt});
            check_eq("bus_error", {31'd0, bus_error}, {31'd0, e.berr});
         end
      end
   end

   // Reference byte/half selection used for the offset sweep.
   function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                            input logic [1:0] off,
                                            input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return rd;
      endcase
   endfunction

   // Present one instruction, play the memory, wait for its writeback.
   // ack_delay: req-high cycles before ack (0 = earliest), -1 = never ack.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [4:0] d, input int ack_delay,
                         input logic [31:0] rdata, input logic [31:0] exp_data,
                         input logic [4:0] exp_dest, input logic exp_flt,
                         input logic exp_berr, input bit chk_data,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      wb_exp_t e;
      int cyc;
      bit bus;
      bus = (ld | st) & ~exp_flt;
      @(negedge clk);
      check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; is_load = ld; is_store = st; func3 = f3;
      result = res; store_data = sd; dest_i = d;
      e.data = exp_data; e.dest = exp_dest; e.flt = exp_flt;
      e.berr = exp_berr; e.chk_data = chk_data;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      cyc = 0;
      if (bus) begin
         for (int i = 0; i < 20; i++) begin
            if (bus_if.mem_req !== 1'b1) break;
            cyc++;
            check_eq("in_ready_wait", {31'd0, in_ready}, 32'd0);
            check_eq("mem_addr", bus_if.mem_addr, {res[31:2], 2'b00});
            check_eq("mem_we", {31'd0, bus_if.mem_we}, {31'd0, st});
            check_eq("mem_wstrb", {28'd0, bus_if.mem_wstrb}, {28'd0, exp_strb});
            if (st) check_eq("mem_wdata", bus_if.mem_wdata, exp_wdata);
            if (ack_delay >= 0 && cyc == ack_delay + 1) begin
               bus_if.mem_ack = 1'b1;
               bus_if.mem_rdata = rdata;
               @(negedge clk);
               bus_if.mem_ack = 1'b0;
               break;
            end
            @(negedge clk);
         end
         if (ack_delay < 0) check_eq("req_cycles", cyc, TMO);
         else check_eq("req_cycles", cyc, ack_delay + 1);
      end
      check_eq("mem_req_low", {31'd0, bus_if.mem_req}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
         #2;
      end
      check_eq("wb_pending", sb.size(), 32'd0);
      sb.delete();
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      func3 = 3'b000; result = 32'd0; store_data = 32'd0; dest_i = 5'd0;
      bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_mem_req", {31'd0, bus_if.mem_req}, 32'd0);
      check_eq("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      check_eq("rst_wb_data", wb_data, 32'd0);
      check_eq("rst_flags", {30'd0, fault, bus_error}, 32'd0);
      reset = 1'b0;

      // ALU pass-through
      run_op(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd3, 0, 32'd0,
             32'h0000_1234, 5'd3, 0, 0, 1, 4'b0000, 32'd0);
      // LB / LBU at 0x103, earliest ack
      run_op(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd5, 0, 32'h8012_3456,
             32'hFFFF_FF80, 5'd5, 0, 0, 1, 4'b0000, 32'd0);
      run_op(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd5, 0, 32'h8012_3456,
             32'h0000_0080, 5'd5, 0, 0, 1, 4'b0000, 32'd0);
      // LH upper half, LHU lower half
      run_op(1, 0, 3'b001, 32'h0000_0102, 32'd0, 5'd6, 1, 32'h8012_3456,
             32'hFFFF_8012, 5'd6, 0, 0, 1, 4'b0000, 32'd0);
      run_op(1, 0, 3'b101, 32'h0000_0100, 32'd0, 5'd6, 0, 32'h8012_F456,
             32'h0000_F456, 5'd6, 0, 0, 1, 4'b0000, 32'd0);
      // Stores
      run_op(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd8, 0, 32'd0,
             32'd0, 5'd0, 0, 0, 1, 4'b1100, 32'hABCD_ABCD);
      run_op(0, 1, 3'b000, 32'h0000_0301, 32'h0000_00AB, 5'd8, 2, 32'd0,
             32'd0, 5'd0, 0, 0, 1, 4'b0010, 32'hABAB_ABAB);
      run_op(0, 1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 5'd8, 0, 32'd0,
             32'd0, 5'd0, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF);
      // LW with ack delayed 3 cycles
      run_op(1, 0, 3'b010, 32'h0000_0040, 32'd0, 5'd9, 3, 32'hCAFE_F00D,
             32'hCAFE_F00D, 5'd9, 0, 0, 1, 4'b0000, 32'd0);
      // Byte-offset sweep against the reference
      for (int off = 0; off < 4; off++) begin
         run_op(1, 0, 3'b000, 32'h0000_0500 + off, 32'd0, 5'd10, 0, 32'h80F1_7F01,
                ref_load(3'b000, 2'(off), 32'h80F1_7F01), 5'd10, 0, 0, 1, 4'b0000, 32'd0);
      end
      // Faults: misaligned and illegal func3
      run_op(1, 0, 3'b010, 32'h0000_0006, 32'd0, 5'd4, 0, 32'd0,
             32'h0000_0006, 5'd0, 1, 0, 1, 4'b0000, 32'd0);
      run_op(1, 0, 3'b001, 32'h0000_0011, 32'd0, 5'd4, 0, 32'd0,
             32'h0000_0011, 5'd0, 1, 0, 1, 4'b0000, 32'd0);
      run_op(1, 0, 3'b011, 32'h0000_0020, 32'd0, 5'd4, 0, 32'd0,
             32'h0000_0020, 5'd0, 1, 0, 1, 4'b0000, 32'd0);
      run_op(0, 1, 3'b100, 32'h0000_0020, 32'h1111_2222, 5'd4, 0, 32'd0,
             32'h0000_0020, 5'd0, 1, 0, 1, 4'b0000, 32'd0);
      // Load to x0: access performed, no register write
      run_op(1, 0, 3'b010, 32'h0000_0080, 32'd0, 5'd0, 0, 32'h1357_9BDF,
             32'h1357_9BDF, 5'd0, 0, 0, 1, 4'b0000, 32'd0);
      // Timeout, then a late ack in IDLE must be ignored
      run_op(1, 0, 3'b010, 32'h0000_0044, 32'd0, 5'd3, -1, 32'd0,
             32'd0, 5'd0, 0, 1, 0, 4'b0000, 32'd0);
      @(negedge clk);
      bus_if.mem_ack = 1'b1; bus_if.mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_if.mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("late_ack_req", {31'd0, bus_if.mem_req}, 32'd0);
      check_eq("late_ack_ready", {31'd0, in_ready}, 32'd1);

      // Reset asserted while a request is outstanding
      @(negedge clk);
      in_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; func3 = 3'b010;
      result = 32'h0000_0048; dest_i = 5'd2;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_req", {31'd0, bus_if.mem_req}, 32'd1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_req", {31'd0, bus_if.mem_req}, 32'd0);
      check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd1);
      check_eq("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(0, 0, 3'b000, 32'h0000_0055, 32'd0, 5'd7, 0, 32'd0,
             32'h0000_0055, 5'd7, 0, 0, 1, 4'b0000, 32'd0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage directly downstream of the execute stage.
- Takes the execute result (effective address or ALU value), store data and destination register.
- Performs byte/half/word loads and stores over a simple req/ack data-memory port.
- Hands a registered value and destination to writeback, and stalls execute while a bus access is outstanding.

Parameters:
- TIMEOUT, 255: cycles mem_req may stay high without mem_ack before a bus error is raised (1..65535).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  execute presents a valid instruction this cycle
- in_ready  out  1  stage can accept; low = stall execute
- is_load  in  1  instruction is a load
- is_store  in  1  instruction is a store
- func3  in  3  RV32I width/sign code
- result  in  32  execute result; effective address when is_load/is_store
- store_data  in  32  rs2 value for stores
- dest_i  in  5  destination register from execute
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({result[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  completes the current request
- wb_valid  out  1  one-cycle pulse, writeback data present
- wb_data  out  32  value to write back
- wb_dest  out  5  register to write; 0 = no write
- fault  out  1  pulses with wb_valid on misaligned access or illegal func3
- bus_error  out  1  pulses with wb_valid on timeout

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0 except in_ready=1; timeout counter 0. An outstanding request is abandoned without waiting for ack.
- Handshake: in_ready = (state==IDLE). A transfer occurs on a rising edge where in_valid && in_ready.
- IDLE, non-memory op (is_load=is_store=0): next cycle wb_valid=1, wb_data=result, wb_dest=dest_i. 1-cycle latency, stay IDLE.
- IDLE, memory op:
  - Check func3. Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW.
  - Check alignment: half needs result[0]=0; word needs result[1:0]=0.
  - Illegal or misaligned: next cycle wb_valid=1, fault=1, wb_dest=0, wb_data=result. No bus access, stay IDLE.
  - Legal: latch address/data/func3/dest, go WAIT. mem_req=1 from the next cycle.
- Store lanes:
  - SB: wstrb = 4'b0001<<result[1:0], wdata = {4{store_data[7:0]}}.
  - SH: wstrb = 4'b0011<<(2*result[1]), wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111, wdata = store_data.
  - Loads: mem_we=0, wstrb=0.
- WAIT:
  - mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until the ack edge.
  - Counter increments each cycle with mem_req high.
  - On mem_ack: mem_req drops the next cycle, wb_valid=1, state returns to IDLE.
    - Load: wb_dest = latched dest. wb_data = byte/half selected by the latched addr[1:0]; sign-extended for LB/LH, zero-extended for LBU/LHU; whole word for LW.
    - Store: wb_dest=0, wb_data=0.
  - Earliest completion: accept at edge N, req high after N, ack sampled at N+1, wb_valid high after N+1.
  - Counter reaching TIMEOUT without ack: mem_req drops, bus_error=1, wb_valid=1, wb_dest=0, return to IDLE, counter cleared.
  - A late mem_ack arriving in IDLE is ignored.
  - mem_ack and timeout on the same edge: ack wins.
- Load to dest_i=0: the access is performed, but wb_dest=0.
- wb_valid, fault and bus_error are single-cycle pulses. wb_data and wb_dest hold until the next wb_valid.
- Back-to-back: a new instruction can be accepted on the edge after returning to IDLE.

Test Plan:
- Reset asserted mid-WAIT (req high) -> immediately mem_req=0, in_ready=1, wb_valid=0. After release, an ALU op result=0x55 dest=7 -> next cycle wb_valid=1, wb_data=0x55, wb_dest=7.
- LB at result=0x103, rdata=0x80123456 acked after 1 cycle -> mem_addr=0x100, wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at result=0x202, store_data=0x1234ABCD -> mem_we=1, mem_addr=0x200, wstrb=4'b1100, wdata=0xABCDABCD. After ack: wb_dest=0, no fault.
- LW at 0x40, ack delayed 3 cycles -> in_ready low and address stable for 4 cycles, then wb_data=rdata, wb_dest=dest_i.
- LW at 0x06 and LH at 0x11 -> fault=1, wb_dest=0, mem_req never asserted. func3=011 load -> fault=1.
- TIMEOUT=4, no ack -> mem_req high exactly 4 cycles, then bus_error=1, wb_valid=1, wb_dest=0. A late ack is ignored.
